// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller:
// FSM state encoding and default PC/timeout parameters.
package fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd32;
    localparam int          DEF_TIMEOUT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request bus.
// master: mem_req/mem_addr out, mem_ready/mem_rdata in.
interface fetch_ctrl_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_wait_timer.sv
// Consecutive wait-cycle counter for one fetch request.
// i_clear wins over i_count; o_timeout flags the cycle that hits TIMEOUT.
module fetch_wait_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count,
    output logic o_timeout
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    // Fires on the wait cycle that makes the count reach TIMEOUT,
    // so the FSM leaves REQ on that same edge.
    assign o_timeout = i_count && !i_clear &&
                       (r_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/REQ/ERR FSM, PC sequencing,
// IR capture with stall hold, redirect/halt and sticky timeout error.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
    parameter int          TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    fetch_ctrl_if.master        mem,
    output logic [31:0]         ir_out,
    output logic [31:0]         pc_out,
    output logic                ir_valid,
    output logic [15:0]         fetch_count,
    output logic                err
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_ERR  = ST_ERR;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_pc_out;
    logic        r_ir_valid;
    logic [15:0] r_fetch_count;
    logic        r_err;

    logic w_in_req;
    logic w_mem_req;
    logic w_hs;
    logic w_wait;
    logic w_clear;
    logic w_timeout;

    assign w_in_req  = (r_state == S_REQ);
    // Back-pressure: no new request while a held word is unaccepted.
    assign w_mem_req = w_in_req && !(r_ir_valid && stall);
    assign w_hs      = w_mem_req && mem.mem_ready;
    assign w_wait    = w_mem_req && !mem.mem_ready;
    assign w_clear   = !w_in_req || halt || redirect_valid || w_hs;

    fetch_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_clear),
        .i_count  (w_wait),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_pc_out      <= '0;
            r_ir_valid    <= 1'b0;
            r_fetch_count <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end
                    if (start) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (halt) begin
                        r_state    <= S_IDLE;
                        r_ir_valid <= 1'b0;
                        if (redirect_valid) begin
                            r_pc <= redirect_pc;
                        end
                    end else if (redirect_valid) begin
                        r_pc       <= redirect_pc;
                        r_ir_valid <= 1'b0;
                    end else if (w_timeout) begin
                        r_state    <= S_ERR;
                        r_err      <= 1'b1;
                        r_ir_valid <= 1'b0;
                    end else if (w_hs) begin
                        r_ir          <= mem.mem_rdata;
                        r_pc_out      <= r_pc;
                        r_ir_valid    <= 1'b1;
                        r_pc          <= r_pc + PC_STEP;
                        r_fetch_count <= r_fetch_count + 16'd1;
                    end else if (r_ir_valid && !stall) begin
                        r_ir_valid <= 1'b0;
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_pc;
    assign ir_out       = r_ir;
    assign pc_out       = r_pc_out;
    assign ir_valid     = r_ir_valid;
    assign fetch_count  = r_fetch_count;
    assign err          = r_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model.
module tb_fetch_ctrl;

    localparam int TO = 16;
    localparam logic [31:0] STEP = 32'd32;
    localparam int M_IDLE = 0;
    localparam int M_REQ  = 1;
    localparam int M_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic [15:0] fetch_count;
    logic        err;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_PC(32'h0),
        .PC_STEP (STEP),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .mem           (bus),
        .ir_out        (ir_out),
        .pc_out        (pc_out),
        .ir_valid      (ir_valid),
        .fetch_count   (fetch_count),
        .err           (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int          m_st;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pco;
    logic        m_v;
    logic [15:0] m_cnt;
    logic        m_err;
    int          m_wait;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_req();
        return (m_st == M_REQ) && !(m_v && stall);
    endfunction

    task automatic model_reset();
        m_st   = M_IDLE;
        m_pc   = 32'h0;
        m_ir   = 32'h0;
        m_pco  = 32'h0;
        m_v    = 1'b0;
        m_cnt  = 16'h0;
        m_err  = 1'b0;
        m_wait = 0;
    endtask

    task automatic model_update();
        logic req;
        req = m_req();
        if (!rst) begin
            model_reset();
        end else if (m_st == M_IDLE) begin
            if (redirect_valid) m_pc = redirect_pc;
            if (start) m_st = M_REQ;
            m_wait = 0;
        end else if (m_st == M_REQ) begin
            if (halt) begin
                m_st = M_IDLE;
                m_v = 1'b0;
                m_wait = 0;
                if (redirect_valid) m_pc = redirect_pc;
            end else if (redirect_valid) begin
                m_pc = redirect_pc;
                m_v = 1'b0;
                m_wait = 0;
            end else if (req && bus.mem_ready) begin
                m_ir  = bus.mem_rdata;
                m_pco = m_pc;
                m_v   = 1'b1;
                m_pc  = m_pc + STEP;
                m_cnt = m_cnt + 16'd1;
                m_wait = 0;
            end else begin
                if (req) m_wait++;
                if (m_v && !stall) m_v = 1'b0;
                if (m_wait == TO) begin
                    m_st = M_ERR;
                    m_err = 1'b1;
                    m_v = 1'b0;
                    m_wait = 0;
                end
            end
        end
    endtask

    task automatic compare();
        chk("mem_req", 32'(bus.mem_req), 32'(m_req()));
        chk("mem_addr", bus.mem_addr, m_pc);
        chk("ir_valid", 32'(ir_valid), 32'(m_v));
        chk("ir_out", ir_out, m_ir);
        chk("pc_out", pc_out, m_pco);
        chk("fetch_count", 32'(fetch_count), 32'(m_cnt));
        chk("err", 32'(err), 32'(m_err));
    endtask

    task automatic drive(input logic r, input logic s, input logic h,
                         input logic rv, input logic [31:0] rp,
                         input logic st, input logic rdy);
        rst = r;
        start = s;
        halt = h;
        redirect_valid = rv;
        redirect_pc = rp;
        stall = st;
        bus.mem_ready = rdy;
        bus.mem_rdata = $urandom;
    endtask

    task automatic step();
        #1;
        compare();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    logic [31:0] hold_ir;
    logic [31:0] hold_pc;
    int rdy_pct;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        model_reset();

        // reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // three back-to-back fetches
        drive(1, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        chk("b2b_pc0", pc_out, 32'd0);
        step();
        chk("b2b_pc1", pc_out, 32'd32);
        step();
        chk("b2b_pc2", pc_out, 32'd64);
        chk("b2b_cnt", 32'(fetch_count), 32'd3);

        // stall holds the captured word
        drive(1, 0, 0, 0, 0, 1, 1);
        hold_ir = ir_out;
        hold_pc = pc_out;
        repeat (4) begin
            step();
            chk("stall_req", 32'(bus.mem_req), 32'd0);
            chk("stall_ir", ir_out, hold_ir);
            chk("stall_pc", pc_out, hold_pc);
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        chk("resume_pc", pc_out, 32'd96);

        // redirect discards a same-cycle handshake
        drive(1, 0, 0, 1, 32'h100, 0, 1);
        step();
        chk("redir_v", 32'(ir_valid), 32'd0);
        chk("redir_addr", bus.mem_addr, 32'h100);
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        chk("redir_pc", pc_out, 32'h100);

        // halt back to idle, then timeout
        drive(1, 0, 1, 0, 0, 0, 1);
        step();
        drive(1, 1, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (TO) step();
        chk("to_err", 32'(err), 32'd1);
        drive(1, 1, 0, 0, 0, 0, 1);
        repeat (3) step();
        chk("to_req", 32'(bus.mem_req), 32'd0);
        chk("to_sticky", 32'(err), 32'd1);

        // pc and fetch_count wrap
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 0, 1, 32'hFFFF_FFE0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 1);
        step();
        chk("wrap_pco", pc_out, 32'hFFFF_FFE0);
        chk("wrap_pc", bus.mem_addr, 32'h0);
        repeat (65535) step();
        chk("wrap_cnt", 32'(fetch_count), 32'd0);

        // reset mid-request with a live handshake
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        chk("rst_v", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir_out, 32'd0);
        chk("rst_cnt", 32'(fetch_count), 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);

        // randomized traffic
        rdy_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rdy_pct = 5;
                    1: rdy_pct = 70;
                    default: rdy_pct = 95;
                endcase
            end
            drive($urandom_range(0, 99) >= 2,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 5,
                  $urandom_range(0, 99) < 5,
                  $urandom,
                  $urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < rdy_pct);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
